// File: rtl/step_counter3.sv
// 3-bit up/down code source for the segment decoder, stepped by a prescaled tick or a push-button.
// Define STEP_COUNTER3_DEBOUNCE_EN to insert the DEB_CYCLES debouncer after the button synchroniser.
module step_counter3 #(
    parameter int unsigned PRESCALE   = 4,
    parameter int unsigned MAX_CODE   = 7,
    parameter int unsigned DEB_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       btn,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       MSB,
    output logic       B,
    output logic       LSB,
    output logic       tc
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic [2:0]  MAX_C    = 3'(MAX_CODE);

    if (PRESCALE < 1 || PRESCALE > 65535 || MAX_CODE < 1 || MAX_CODE > 7 ||
        DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_bad_param
        $error("step_counter3: parameter out of legal range");
    end

    function automatic logic [2:0] sat_code(input logic [2:0] v);
        return (v > MAX_C) ? MAX_C : v;
    endfunction

    logic [2:0]  code_q, code_d;
    logic        tc_q, tc_d;
    logic [15:0] pre_q, pre_d;
    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        lvl_q, lvl_d;
    logic        lvl;
    logic        tick;
    logic        press;

`ifdef STEP_COUNTER3_DEBOUNCE_EN
    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    logic       db_q, db_d;
    logic [7:0] cnt_q, cnt_d;

    // A level change is accepted only after DEB_CYCLES consecutive differing samples.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == DEB_LAST) begin
                db_d = s2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign lvl = db_q;
`else
    assign lvl = s2_q;
`endif

    always_comb begin
        s1_d   = btn;
        s2_d   = s1_q;
        lvl_d  = lvl;
        press  = lvl & ~lvl_q;
        tick   = en & ~load & (pre_q == PRE_LAST);
        pre_d  = pre_q + 16'd1;
        code_d = code_q;
        tc_d   = 1'b0;

        if (!en || load || pre_q == PRE_LAST) begin
            pre_d = '0;
        end

        // Load wins over a coincident step; tick and press merge into a single step.
        if (load) begin
            code_d = sat_code(load_val);
        end else if (tick || press) begin
            if (up) begin
                if (code_q == MAX_C) begin
                    code_d = 3'd0;
                    tc_d   = 1'b1;
                end else begin
                    code_d = code_q + 3'd1;
                end
            end else begin
                if (code_q == 3'd0) begin
                    code_d = MAX_C;
                    tc_d   = 1'b1;
                end else begin
                    code_d = code_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code_q <= '0;
            tc_q   <= 1'b0;
            pre_q  <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            tc_q   <= tc_d;
            pre_q  <= pre_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
        end
    end

    assign MSB = code_q[2];
    assign B   = code_q[1];
    assign LSB = code_q[0];
    assign tc  = tc_q;

endmodule

// File: tb/tb_step_counter3.sv
// Bench for step_counter3: directed scenarios plus random stimulus against a behavioural model.
module tb_step_counter3;

    localparam int PRESCALE   = 4;
    localparam int MAX_CODE   = 5;
    localparam int DEB_CYCLES = 3;
`ifdef STEP_COUNTER3_DEBOUNCE_EN
    localparam int PRESS_LAT    = DEB_CYCLES + 2;
    localparam int GLITCH_STEPS = 0;
`else
    localparam int PRESS_LAT    = 2;
    localparam int GLITCH_STEPS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       btn = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       MSB, B, LSB, tc;

    int n_checks = 0;
    int n_errors = 0;

    step_counter3 #(
        .PRESCALE  (PRESCALE),
        .MAX_CODE  (MAX_CODE),
        .DEB_CYCLES(DEB_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .btn     (btn),
        .load    (load),
        .load_val(load_val),
        .MSB     (MSB),
        .B       (B),
        .LSB     (LSB),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int want);
        n_checks++;
        if (obs !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
        end
    endtask

    // Model state: btn samples (for the 2-cycle synchroniser delay) and the
    // button level as seen after each of the last two edges.
    int m_code = 0;
    bit m_tc = 1'b0;
    int m_run = 0;
    bit m_hist[$];
    bit m_lvl1 = 1'b0;
    bit m_lvl2 = 1'b0;
`ifdef STEP_COUNTER3_DEBOUNCE_EN
    bit m_sy[$];
    bit m_db = 1'b0;
`endif

    task automatic model_edge();
        bit tick, press, newlvl;
        if (rst) begin
            m_code = 0; m_tc = 1'b0; m_run = 0;
            m_hist = {1'b0, 1'b0};
            m_lvl1 = 1'b0; m_lvl2 = 1'b0;
`ifdef STEP_COUNTER3_DEBOUNCE_EN
            m_sy = {};
            m_db = 1'b0;
`endif
            return;
        end
        press = m_lvl1 & ~m_lvl2;
`ifdef STEP_COUNTER3_DEBOUNCE_EN
        begin
            bit all_diff;
            m_sy.push_back(m_hist[m_hist.size()-2]);
            if (m_sy.size() > DEB_CYCLES) void'(m_sy.pop_front());
            all_diff = (m_sy.size() == DEB_CYCLES);
            foreach (m_sy[i]) if (m_sy[i] == m_db) all_diff = 1'b0;
            if (all_diff) m_db = ~m_db;
        end
`endif
        m_hist.push_back(btn);
        if (m_hist.size() > 3) void'(m_hist.pop_front());
`ifdef STEP_COUNTER3_DEBOUNCE_EN
        newlvl = m_db;
`else
        newlvl = m_hist[m_hist.size()-2];
`endif
        m_lvl2 = m_lvl1;
        m_lvl1 = newlvl;

        if (load || !en) begin
            m_run = 0;
            tick = 1'b0;
        end else begin
            m_run++;
            tick = (m_run % PRESCALE) == 0;
        end

        m_tc = 1'b0;
        if (load) begin
            m_code = (int'(load_val) > MAX_CODE) ? MAX_CODE : int'(load_val);
        end else if (tick || press) begin
            if (up) begin
                m_tc   = (m_code == MAX_CODE);
                m_code = (m_code + 1) % (MAX_CODE + 1);
            end else begin
                m_tc   = (m_code == 0);
                m_code = (m_code + MAX_CODE) % (MAX_CODE + 1);
            end
        end
    endtask

    function automatic int dut_code();
        return int'({MSB, B, LSB});
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("code", dut_code(), m_code);
        check("tc", int'(tc), int'(m_tc));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; btn = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int base;

        do_reset();
        check("rst_code", dut_code(), 0);
        check("rst_tc", int'(tc), 0);

        // Auto up: wrap to 0 at edge 24
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            cycle();
            if (i % 4 == 0) check("auto_up", dut_code(), (i / 4) % (MAX_CODE + 1));
            check("auto_up_tc", int'(tc), (i == 24) ? 1 : 0);
        end

        // Auto down from 0
        do_reset();
        en = 1'b1; up = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (i == 4) begin
                check("down_wrap", dut_code(), MAX_CODE);
                check("down_wrap_tc", int'(tc), 1);
            end
            if (i == 8) check("down_step", dut_code(), MAX_CODE - 1);
        end

        // Load saturates
        en = 1'b0; load = 1'b1; load_val = 3'd6;
        cycle();
        check("load_sat", dut_code(), MAX_CODE);
        check("load_tc", int'(tc), 0);
        load = 1'b0;

        // Load coinciding with a tick
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (11) cycle();
        check("pre_load", dut_code(), 2);
        load = 1'b1; load_val = 3'd1;
        cycle();
        check("load_on_tick", dut_code(), 1);
        load = 1'b0;
        repeat (3) cycle();
        check("after_load_hold", dut_code(), 1);
        cycle();
        check("after_load_step", dut_code(), 2);

        // Short button glitch with en=0
        en = 1'b0; load = 1'b1; load_val = 3'd0;
        cycle();
        load = 1'b0;
        btn = 1'b1;
        repeat (2) cycle();
        btn = 1'b0;
        repeat (8) cycle();
        check("glitch", dut_code(), GLITCH_STEPS);

        // Long press: one step at PRESS_LAT, none on release
        base = dut_code();
        btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (i == PRESS_LAT - 1) check("press_early", dut_code(), base);
            if (i == PRESS_LAT) check("press_step", dut_code(), (base + 1) % (MAX_CODE + 1));
        end
        btn = 1'b0;
        repeat (10) cycle();
        check("release", dut_code(), (base + 1) % (MAX_CODE + 1));

        // Press landing on a tick edge
        do_reset();
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            btn = (i >= 8 - PRESS_LAT && i < 8 - PRESS_LAT + 8);
            cycle();
        end
        check("press_on_tick", dut_code(), 3);
        btn = 1'b0;
        repeat (10) cycle();

        // Reset mid-run with a half-debounced press
        do_reset();
        en = 1'b1; up = 1'b1;
        repeat (12) cycle();
        check("mid_code", dut_code(), 3);
        en = 1'b0; btn = 1'b1;
        repeat (2) cycle();
        btn = 1'b0; rst = 1'b1;
        cycle();
        check("mid_rst_code", dut_code(), 0);
        check("mid_rst_tc", int'(tc), 0);
        rst = 1'b0;
        repeat (8) cycle();
        check("mid_after", dut_code(), 0);

        // Random traffic
        begin
            int hold = 0;
            for (int i = 0; i < 3000; i++) begin
                rst  = ($urandom_range(99) == 0);
                load = ($urandom_range(24) == 0);
                load_val = 3'($urandom_range(7));
                if ($urandom_range(19) == 0) en = ~en;
                if ($urandom_range(29) == 0) up = ~up;
                if (hold == 0) begin
                    btn  = ~btn;
                    hold = $urandom_range(1, 8);
                end
                hold--;
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
